bram_arbiter: RTL and testbench
===============================

BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 Parameter: BRAM_WIDTH, default 64, memory word width.
REQ-002 Parameter: BRAM_ADDR_WIDTH, default 10, word address width.
REQ-003 Parameter: MAX_WAIT, default 8, host starvation bound in cycles; legal range 1..255.
REQ-004 Port: clk  in  1  single clock; all logic on its rising edge.
REQ-005 Port: rst  in  1  synchronous, active-high reset.
REQ-006 Port: host_valid/host_ready  in/out  1/1  host request handshake.
REQ-007 Port: host_we  in  1  1 = write, 0 = read.
REQ-008 Port: host_addr/host_wdata  in  BRAM_ADDR_WIDTH/BRAM_WIDTH  host address and write data.
REQ-009 Port: host_rdata/host_rvalid  out  BRAM_WIDTH/1  host read return.
REQ-010 Port: cop_valid/cop_ready  in/out  1/1  coprocessor read-request handshake.
REQ-011 Port: cop_addr  in  BRAM_ADDR_WIDTH  coprocessor read address.
REQ-012 Port: cop_rdata/cop_rvalid  out  BRAM_WIDTH/1  coprocessor read return.
REQ-013 Port: bram_r_addr/bram_r_valid/bram_r_data  out/out/in  BRAM_ADDR_WIDTH/1/BRAM_WIDTH  BRAM read port; data arrives 1 cycle after bram_r_valid.
REQ-014 Port: bram_w_addr/bram_w_data/bram_w_valid  out  BRAM_ADDR_WIDTH/BRAM_WIDTH/1  BRAM write port.
REQ-015 Port: host_lock  in  1  when 1, the coprocessor is never granted.

Function
REQ-016 At most one grant per cycle; a grant occurs when the granted requester's valid and ready are both 1 in the same cycle.
REQ-017 ready outputs are combinational from valid, state, and wait counter; a requester's ready is never asserted unless it wins.
REQ-018 FSM states: ARB_COP_PRIO and ARB_HOST_FORCED.
REQ-019 ARB_COP_PRIO: cop wins if cop_valid and !host_lock; otherwise host wins if host_valid.
REQ-020 Wait counter (8 bits) increments each cycle host_valid=1 and the host is not granted; it clears on a host grant.
REQ-021 When the wait counter reaches MAX_WAIT, the FSM moves to ARB_HOST_FORCED.
REQ-022 ARB_HOST_FORCED: the host wins unconditionally; after the host grant, the FSM returns to ARB_COP_PRIO.
REQ-023 If host_valid drops while in ARB_HOST_FORCED, the FSM returns to ARB_COP_PRIO and the counter clears.
REQ-024 A host write grant drives bram_w_* in the same cycle; no rvalid is produced.
REQ-025 A read grant drives bram_r_addr and bram_r_valid=1 in the same cycle.
REQ-026 A 1-bit owner tag is registered for each read grant; exactly one cycle later, the owner's rvalid=1 and its rdata=bram_r_data.
REQ-027 Throughput: back-to-back reads from either requester are sustained at 1 per cycle.
REQ-028 rvalid is never delayed or dropped; requesters always accept.
REQ-029 With no grant, all bram_*_valid=0 and all addr/data outputs=0.
REQ-030 With host_lock=1, cop_ready=0 while a cop read already granted still returns.

Reset
REQ-031 Reset conditions: FSM=ARB_COP_PRIO, wait counter=0, owner tag/pending flag=0.
REQ-032 During reset, all ready, rvalid, and bram valid outputs=0.
REQ-033 Reset mid-read discards the return; no rvalid in the cycle after reset.

Configuration
REQ-034 Macro BRAM_ARB_STATS_EN adds outputs stat_host_grants and stat_cop_grants (32 bit each, saturating at all-ones, cleared by rst).
REQ-035 Without BRAM_ARB_STATS_EN, these ports and counters are absent and all other behaviour is identical.

Structure
REQ-036 The state enum arb_state_t and the owner-tag constants live in the shared AXI_package.
REQ-037 The arbitration decision logic is implemented as one combinational sub-module, bram_arb_grant.
REQ-038 The FSM, counter, tag, and stats logic stay in bram_arbiter.

Verification
REQ-039 Host write addr 5, data 0xA5, then host read addr 5 -> host_rvalid 1 cycle after the read grant, host_rdata=0xA5, cop_rvalid=0.
REQ-040 cop_valid held high with continuous reads, host_valid=1 (MAX_WAIT=8) -> host granted exactly on the 9th cycle, then cop resumes next cycle.
REQ-041 host_lock=1, cop_valid=1, host idle -> cop_ready=0, no BRAM activity.
REQ-042 Alternating cop/host reads at addrs 1/2 every cycle -> each rdata is routed to the correct owner with 1-cycle latency.
REQ-043 rst asserted the cycle after a cop grant -> cop_rvalid=0 next cycle, FSM=ARB_COP_PRIO.
REQ-044 With BRAM_ARB_STATS_EN: 3 host and 4 cop grants -> stat_host_grants=3, stat_cop_grants=4.

Source files
------------

// File: rtl/AXI_package.sv
// Shared arbiter types: FSM state encoding, read-owner tag values and counter width.
package AXI_package;

    typedef enum logic [0:0] {
        ARB_COP_PRIO    = 1'b0,
        ARB_HOST_FORCED = 1'b1
    } arb_state_t;

    localparam logic OWNER_HOST = 1'b0;
    localparam logic OWNER_COP  = 1'b1;

    localparam int WAIT_W = 8;

endpackage

// File: rtl/bram_arb_grant.sv
// Combinational arbitration decision between host and coprocessor; at most one grant per cycle.
module bram_arb_grant (
    input  logic en,
    input  logic host_forced,
    input  logic host_valid,
    input  logic cop_valid,
    input  logic host_lock,
    output logic host_grant,
    output logic cop_grant
);

    always_comb begin
        host_grant = 1'b0;
        cop_grant  = 1'b0;
        if (en) begin
            if (host_forced) begin
                host_grant = host_valid;
            end else if (cop_valid && !host_lock) begin
                cop_grant = 1'b1;
            end else begin
                host_grant = host_valid;
            end
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// Host/coprocessor arbiter for a single BRAM, with a host starvation bound.
// Optional grant statistics are enabled with the BRAM_ARB_STATS_EN macro.
module bram_arbiter
    import AXI_package::*;
#(
    parameter int BRAM_WIDTH      = 64,
    parameter int BRAM_ADDR_WIDTH = 10,
    parameter int MAX_WAIT        = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       host_valid,
    output logic                       host_ready,
    input  logic                       host_we,
    input  logic [BRAM_ADDR_WIDTH-1:0] host_addr,
    input  logic [BRAM_WIDTH-1:0]      host_wdata,
    output logic [BRAM_WIDTH-1:0]      host_rdata,
    output logic                       host_rvalid,
    input  logic                       cop_valid,
    output logic                       cop_ready,
    input  logic [BRAM_ADDR_WIDTH-1:0] cop_addr,
    output logic [BRAM_WIDTH-1:0]      cop_rdata,
    output logic                       cop_rvalid,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_r_addr,
    output logic                       bram_r_valid,
    input  logic [BRAM_WIDTH-1:0]      bram_r_data,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_w_addr,
    output logic [BRAM_WIDTH-1:0]      bram_w_data,
    output logic                       bram_w_valid,
    input  logic                       host_lock
`ifdef BRAM_ARB_STATS_EN
    ,
    output logic [31:0]                stat_host_grants,
    output logic [31:0]                stat_cop_grants
`endif
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_W = WAIT_W'(MAX_WAIT);

    arb_state_t        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              pend_q, pend_d;
    logic              owner_q, owner_d;
    logic              host_grant, cop_grant, rd_grant;

    bram_arb_grant u_grant (
        .en          (!rst),
        .host_forced (state_q == ARB_HOST_FORCED),
        .host_valid  (host_valid),
        .cop_valid   (cop_valid),
        .host_lock   (host_lock),
        .host_grant  (host_grant),
        .cop_grant   (cop_grant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_COP_PRIO;
            wait_q  <= '0;
            pend_q  <= 1'b0;
            owner_q <= OWNER_HOST;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            pend_q  <= pend_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        wait_d = wait_q;
        if (host_grant || (state_q == ARB_HOST_FORCED && !host_valid)) begin
            wait_d = '0;
        end else if (host_valid && wait_q != '1) begin
            wait_d = wait_q + 1'b1;
        end
    end

    // Forced state lasts one cycle: the host is either granted or has withdrawn.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_COP_PRIO:    if (wait_d >= MAX_WAIT_W) state_d = ARB_HOST_FORCED;
            ARB_HOST_FORCED: state_d = ARB_COP_PRIO;
            default:         state_d = ARB_COP_PRIO;
        endcase
    end

    always_comb begin
        rd_grant     = cop_grant || (host_grant && !host_we);
        host_ready   = host_grant;
        cop_ready    = cop_grant;
        bram_r_valid = rd_grant;
        bram_r_addr  = '0;
        if (cop_grant) begin
            bram_r_addr = cop_addr;
        end else if (host_grant && !host_we) begin
            bram_r_addr = host_addr;
        end
        bram_w_valid = host_grant && host_we;
        bram_w_addr  = bram_w_valid ? host_addr  : '0;
        bram_w_data  = bram_w_valid ? host_wdata : '0;
    end

    always_comb begin
        pend_d  = rd_grant;
        owner_d = cop_grant ? OWNER_COP : OWNER_HOST;
    end

    // Gating with rst drops a return that was in flight when reset hit.
    assign host_rvalid = pend_q && !rst && (owner_q == OWNER_HOST);
    assign cop_rvalid  = pend_q && !rst && (owner_q == OWNER_COP);
    assign host_rdata  = host_rvalid ? bram_r_data : '0;
    assign cop_rdata   = cop_rvalid  ? bram_r_data : '0;

`ifdef BRAM_ARB_STATS_EN
    logic [31:0] stat_host_q, stat_host_d, stat_cop_q, stat_cop_d;

    always_comb begin
        stat_host_d = stat_host_q;
        stat_cop_d  = stat_cop_q;
        if (host_grant && stat_host_q != '1) stat_host_d = stat_host_q + 1'b1;
        if (cop_grant && stat_cop_q != '1)   stat_cop_d  = stat_cop_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_host_q <= '0;
            stat_cop_q  <= '0;
        end else begin
            stat_host_q <= stat_host_d;
            stat_cop_q  <= stat_cop_d;
        end
    end

    assign stat_host_grants = stat_host_q;
    assign stat_cop_grants  = stat_cop_q;
`endif

endmodule

// File: tb/tb_bram_arbiter.sv
// Randomised and directed bench for bram_arbiter against a behavioural arbitration/memory model.
module tb_bram_arbiter;
    import AXI_package::*;

    localparam int DW = 64;
    localparam int AW = 10;
    localparam int MW = 8;

    logic          clk = 1'b0;
    logic          rst, host_valid, host_we, cop_valid, host_lock, mem_clear;
    logic [AW-1:0] host_addr, cop_addr, bram_r_addr, bram_w_addr;
    logic [DW-1:0] host_wdata, host_rdata, cop_rdata, bram_r_data, bram_w_data;
    logic          host_ready, host_rvalid, cop_ready, cop_rvalid, bram_r_valid, bram_w_valid;
`ifdef BRAM_ARB_STATS_EN
    logic [31:0]   stat_host_grants, stat_cop_grants;
`endif

    bram_arbiter #(.BRAM_WIDTH(DW), .BRAM_ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .cop_valid(cop_valid), .cop_ready(cop_ready), .cop_addr(cop_addr),
        .cop_rdata(cop_rdata), .cop_rvalid(cop_rvalid),
        .bram_r_addr(bram_r_addr), .bram_r_valid(bram_r_valid), .bram_r_data(bram_r_data),
        .bram_w_addr(bram_w_addr), .bram_w_data(bram_w_data), .bram_w_valid(bram_w_valid),
        .host_lock(host_lock)
`ifdef BRAM_ARB_STATS_EN
        , .stat_host_grants(stat_host_grants), .stat_cop_grants(stat_cop_grants)
`endif
    );

    always #5 clk = ~clk;

    // BRAM with one cycle read latency
    logic [DW-1:0] bram_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < (1 << AW); i++) bram_mem[i] <= '0;
        end else begin
            if (bram_w_valid) bram_mem[bram_w_addr] <= bram_w_data;
            if (bram_r_valid) bram_r_data <= bram_mem[bram_r_addr];
        end
    end

    // Reference model state
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            m_wait, m_pend, m_host_grants, m_cop_grants;
    bit            m_forced;
    logic [DW-1:0] m_pend_data;
    int            n_tests = 0, n_fail = 0;
    logic          snap_host_ready, snap_cop_ready, snap_host_rvalid, snap_cop_rvalid, snap_r_valid;
    logic [DW-1:0] snap_host_rdata, snap_cop_rdata;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // 0 = none, 1 = host, 2 = cop
    function automatic int predict_grant();
        if (rst) return 0;
        if (m_forced) return host_valid ? 1 : 0;
        if (cop_valid && !host_lock) return 2;
        return host_valid ? 1 : 0;
    endfunction

    task automatic check_outputs();
        int   g;
        logic hrd, exp_hrv, exp_crv;
        g   = predict_grant();
        hrd = (g == 1) && !host_we;
        check_eq("host_ready", host_ready, g == 1);
        check_eq("cop_ready", cop_ready, g == 2);
        check_eq("bram_r_valid", bram_r_valid, (g == 2) || hrd);
        check_eq("bram_r_addr", bram_r_addr, (g == 2) ? cop_addr : (hrd ? host_addr : '0));
        check_eq("bram_w_valid", bram_w_valid, (g == 1) && host_we);
        check_eq("bram_w_addr", bram_w_addr, ((g == 1) && host_we) ? host_addr : '0);
        check_eq("bram_w_data", bram_w_data, ((g == 1) && host_we) ? host_wdata : '0);
        exp_hrv = !rst && (m_pend == 0);
        exp_crv = !rst && (m_pend == 1);
        check_eq("host_rvalid", host_rvalid, exp_hrv);
        check_eq("cop_rvalid", cop_rvalid, exp_crv);
        if (exp_hrv) check_eq("host_rdata", host_rdata, m_pend_data);
        if (exp_crv) check_eq("cop_rdata", cop_rdata, m_pend_data);
    endtask

    task automatic model_update();
        int g;
        g = predict_grant();
        if (rst) begin
            m_wait = 0; m_forced = 0; m_pend = -1;
            m_host_grants = 0; m_cop_grants = 0;
            return;
        end
        m_pend = -1;
        if (g == 2) begin
            m_cop_grants++;
            m_pend = 1;
            m_pend_data = ref_mem[cop_addr];
        end else if (g == 1) begin
            m_host_grants++;
            if (host_we) ref_mem[host_addr] = host_wdata;
            else begin
                m_pend = 0;
                m_pend_data = ref_mem[host_addr];
            end
        end
        // Host starvation: count waiting cycles, force the host once the bound is hit
        if (g == 1) begin
            m_wait = 0; m_forced = 0;
        end else if (host_valid) begin
            if (m_wait < 255) m_wait++;
            if (m_wait >= MW) m_forced = 1;
        end else if (m_forced) begin
            m_wait = 0; m_forced = 0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        snap_host_ready  = host_ready;
        snap_cop_ready   = cop_ready;
        snap_host_rvalid = host_rvalid;
        snap_cop_rvalid  = cop_rvalid;
        snap_host_rdata  = host_rdata;
        snap_cop_rdata   = cop_rdata;
        snap_r_valid     = bram_r_valid;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        rst = 0; host_valid = 0; host_we = 0; host_addr = '0; host_wdata = '0;
        cop_valid = 0; cop_addr = '0; host_lock = 0;
    endtask

    task automatic host_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        host_valid = 1; host_we = we; host_addr = a; host_wdata = d;
    endtask

    initial begin
        int grant_cycle;
        idle();
        rst = 1; mem_clear = 1;
        m_wait = 0; m_forced = 0; m_pend = -1; m_host_grants = 0; m_cop_grants = 0;
        m_pend_data = '0;
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
        host_valid = 1; cop_valid = 1;
        step(); step();
        check_eq("rst_host_ready", snap_host_ready, 0);
        check_eq("rst_cop_ready", snap_cop_ready, 0);
        check_eq("rst_state", 64'(dut.state_q), 64'(ARB_COP_PRIO));
        check_eq("rst_wait", 64'(dut.wait_q), 0);
        idle(); mem_clear = 0;
        step();

        // Write then read back through the host
        host_op(1, 5, 64'hA5); step();
        host_op(0, 5, '0); step();
        idle(); step();
        check_eq("wr_rd_rvalid", snap_host_rvalid, 1);
        check_eq("wr_rd_rdata", snap_host_rdata, 64'hA5);
        check_eq("wr_rd_cop_rvalid", snap_cop_rvalid, 0);

        // Starvation bound with cop streaming reads
        cop_valid = 1; cop_addr = 3; host_op(0, 5, '0);
        grant_cycle = 0;
        for (int i = 1; i <= 20 && grant_cycle == 0; i++) begin
            step();
            if (snap_host_ready) grant_cycle = i;
        end
        check_eq("starve_grant_cycle", grant_cycle, MW + 1);
        step();
        check_eq("starve_cop_resume", snap_cop_ready, 1);
        idle(); step();

        // Lock with cop only
        host_lock = 1; cop_valid = 1; cop_addr = 7;
        repeat (3) step();
        check_eq("lock_cop_ready", snap_cop_ready, 0);
        check_eq("lock_bram_r_valid", snap_r_valid, 0);
        idle();

        // Alternating owners
        host_op(1, 1, 64'h1111_0000_1111_0001); step();
        host_op(1, 2, 64'h2222_0000_2222_0002); step();
        idle();
        for (int i = 0; i < 8; i++) begin
            idle();
            if (i % 2 == 0) begin cop_valid = 1; cop_addr = 1; end
            else host_op(0, 2, '0);
            step();
            if (i > 0 && i % 2 == 0) check_eq("alt_host_rdata", snap_host_rdata, 64'h2222_0000_2222_0002);
            if (i % 2 == 1) check_eq("alt_cop_rdata", snap_cop_rdata, 64'h1111_0000_1111_0001);
        end
        idle(); step();

        // Reset right after a cop grant
        cop_valid = 1; cop_addr = 1; step();
        idle(); rst = 1; step();
        check_eq("rst_mid_rvalid", snap_cop_rvalid, 0);
        rst = 0; step();
        check_eq("rst_after_rvalid", snap_cop_rvalid, 0);
        check_eq("rst_after_state", 64'(dut.state_q), 64'(ARB_COP_PRIO));

`ifdef BRAM_ARB_STATS_EN
        rst = 1; step(); rst = 0;
        for (int i = 0; i < 7; i++) begin
            idle();
            if (i < 3) host_op(0, 10'(i), '0);
            else begin cop_valid = 1; cop_addr = 10'(i); end
            step();
        end
        idle(); step();
        check_eq("stat_host_3", stat_host_grants, 3);
        check_eq("stat_cop_4", stat_cop_grants, 4);
`endif

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 199) == 0);
            host_valid = ($urandom_range(0, 2) != 0);
            host_we    = $urandom_range(0, 1);
            host_addr  = 10'($urandom_range(0, 15));
            host_wdata = {$urandom, $urandom};
            cop_valid  = ($urandom_range(0, 3) != 0);
            cop_addr   = 10'($urandom_range(0, 15));
            host_lock  = ($urandom_range(0, 9) == 0);
            step();
`ifdef BRAM_ARB_STATS_EN
            check_eq("stat_host", stat_host_grants, m_host_grants);
            check_eq("stat_cop", stat_cop_grants, m_cop_grants);
`endif
        end
        idle(); step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
